// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
// Optional feature: define SPI_AUTOINC_EN to enable address auto-increment.
package spi_reg_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CMD_WR_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // 7-bit modulo increment (0x7F wraps to 0x00)
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// Bundles the SPI pins and the register-bank bus of the SPI register slave.
// slave modport = the spi_reg_slave side, master modport = SPI host plus bank.
interface spi_reg_if;
    import spi_reg_pkg::*;

    logic              my_spi_ss;
    logic              my_spi_sck;
    logic              my_spi_mosi;
    logic              my_spi_miso;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;

    modport slave (
        input  my_spi_ss, my_spi_sck, my_spi_mosi, reg_rdata,
        output my_spi_miso, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output my_spi_ss, my_spi_sck, my_spi_mosi, reg_rdata,
        input  my_spi_miso, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// detection taken from the synchronized samples.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_meta;
    logic       r_prev;

    // Synchronizer chain and previous-sample register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {2{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_meta <= {r_meta[0], i_async};
            r_prev <= r_meta[1];
        end
    end

    assign o_sync = r_meta[1];
    assign o_rise = r_meta[1] & ~r_prev;
    assign o_fall = ~r_meta[1] & r_prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave bridging to a simple register bank (7-bit address, 8-bit
// data). First byte is the command (bit 7 = write), following bytes are data.
// Optional feature: define SPI_AUTOINC_EN to advance reg_addr after each
// data byte; otherwise the address stays fixed for the whole frame.
module spi_reg_slave
    import spi_reg_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    spi_reg_if.slave  bus
);

    logic w_ss, w_ss_rise, w_ss_fall;
    logic w_sck, w_sck_rise, w_sck_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;

    spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_async(bus.my_spi_ss),
        .o_sync(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .i_async(bus.my_spi_sck),
        .o_sync(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(bus.my_spi_mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = w_sck ^ w_mosi_rise ^ w_mosi_fall;

    state_e            r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx;
    logic [DATA_W-1:0] r_tx;
    logic              r_miso;
    logic              r_wr;
    logic              r_we;
    logic              r_re;
    logic              r_ld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_settle;
    logic              r_armed;

    logic [DATA_W-1:0] w_byte;
    logic              w_byte_done;

    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);

    // Arm frame start only after the synchronizers hold real samples and ss
    // has been seen high, so a reset released mid-frame cannot fake a ss fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else if (r_settle != 2'd3) begin
            r_settle <= r_settle + 2'd1;
        end else if (w_ss) begin
            r_armed  <= 1'b1;
        end
    end

    // Frame FSM, shift registers and register-bus strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
            r_tx      <= '0;
            r_miso    <= 1'b0;
            r_wr      <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_ld      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            r_ld <= r_re;
            if (w_ss_rise) begin
                // End of frame wins over everything, including a byte that
                // completes in this same cycle: partial data is dropped
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_rx      <= 7'd0;
                r_tx      <= '0;
                r_miso    <= 1'b0;
                r_ld      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall && r_armed) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= 3'd0;
                            r_rx      <= 7'd0;
                            r_tx      <= '0;
                            r_miso    <= 1'b0;
                        end
                    end
                    ST_CMD, ST_DATA: begin
                        if (w_sck_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_rx      <= w_byte[6:0];
                        end
                        if (w_sck_fall) begin
                            r_miso <= r_tx[DATA_W-1];
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                        // Read data arrives one cycle after reg_re, well
                        // before the byte-boundary sck fall that shifts it out
                        if (r_ld) begin
                            r_tx <= bus.reg_rdata;
                        end
                        if (w_byte_done) begin
                            if (r_state == ST_CMD) begin
                                r_addr  <= w_byte[ADDR_W-1:0];
                                r_wr    <= w_byte[CMD_WR_BIT];
                                r_re    <= ~w_byte[CMD_WR_BIT];
                                r_state <= ST_DATA;
                            end else if (r_wr) begin
                                r_wdata <= w_byte;
                                r_we    <= 1'b1;
                            end else begin
                                r_re    <= 1'b1;
`ifdef SPI_AUTOINC_EN
                                r_addr  <= addr_next(r_addr);
`endif
                            end
                        end
`ifdef SPI_AUTOINC_EN
                        if (r_we) begin
                            r_addr <= addr_next(r_addr);
                        end
`endif
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.my_spi_miso = r_miso & ~bus.my_spi_ss;
    assign bus.reg_addr    = r_addr;
    assign bus.reg_wdata   = r_wdata;
    assign bus.reg_we      = r_we;
    assign bus.reg_re      = r_re;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_slave.sv
// Testbench for spi_reg_slave: table of SPI frames plus hand-written
// abort and mid-frame reset sequences. Expected writes go through a queue.
module tb_spi_reg_slave;
    import spi_reg_pkg::*;

    localparam int HALF = 160;   // sck half period = 8 clk periods (clk/16)

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_reg_if bus();

    spi_reg_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [23:0] mosi;   // three bytes, command first
        logic        rd;
        logic [13:0] wa;     // expected write addresses {first, second}
        logic [15:0] wd;     // expected write data {first, second}
        logic [23:0] miso;   // expected MISO bytes for read frames
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   re_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Register bank model and write scoreboard, sampled on the falling clk edge
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.reg_rdata = 8'h00;
        end else begin
            if (bus.reg_re) begin
                re_cnt++;
                bus.reg_rdata = {1'b0, bus.reg_addr} + 8'h40;
            end
            if (bus.reg_we) begin
                we_cnt++;
                chk("we_re_exclusive", int'(bus.reg_re), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_we_addr", int'(bus.reg_addr), -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("we_addr", int'(bus.reg_addr), int'(e.addr));
                    chk("we_data", int'(bus.reg_wdata), int'(e.data));
                end
            end
        end
    end

    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.my_spi_mosi = mo[i];
            #HALF;
            mi[i] = bus.my_spi_miso;
            bus.my_spi_sck = 1'b1;
            #HALF;
            bus.my_spi_sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        bus.my_spi_ss = 1'b0;
        #HALF;
    endtask

    task automatic ss_high();
        #HALF;
        bus.my_spi_ss = 1'b1;
        #(2 * HALF);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr",  int'(bus.reg_addr),    0);
        chk("rst_wdata", int'(bus.reg_wdata),   0);
        chk("rst_we",    int'(bus.reg_we),      0);
        chk("rst_re",    int'(bus.reg_re),      0);
        chk("rst_busy",  int'(bus.busy),        0);
        chk("rst_miso",  int'(bus.my_spi_miso), 0);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] rx[3];
        int we0;
        int re0;

        bus.my_spi_ss   = 1'b1;
        bus.my_spi_sck  = 1'b0;
        bus.my_spi_mosi = 1'b0;

`ifdef SPI_AUTOINC_EN
        vecs[0] = '{mosi: 24'h85AA55, rd: 1'b0, wa: {7'h05, 7'h06}, wd: 16'hAA55, miso: 24'h0};
        vecs[1] = '{mosi: 24'h100000, rd: 1'b1, wa: 14'h0, wd: 16'h0, miso: 24'h005051};
        vecs[2] = '{mosi: 24'hFF0102, rd: 1'b0, wa: {7'h7F, 7'h00}, wd: 16'h0102, miso: 24'h0};
        vecs[3] = '{mosi: 24'h831122, rd: 1'b0, wa: {7'h03, 7'h04}, wd: 16'h1122, miso: 24'h0};
        vecs[4] = '{mosi: 24'h7F0000, rd: 1'b1, wa: 14'h0, wd: 16'h0, miso: 24'h00BF40};
`else
        vecs[0] = '{mosi: 24'h85AA55, rd: 1'b0, wa: {7'h05, 7'h05}, wd: 16'hAA55, miso: 24'h0};
        vecs[1] = '{mosi: 24'h100000, rd: 1'b1, wa: 14'h0, wd: 16'h0, miso: 24'h005050};
        vecs[2] = '{mosi: 24'hFF0102, rd: 1'b0, wa: {7'h7F, 7'h7F}, wd: 16'h0102, miso: 24'h0};
        vecs[3] = '{mosi: 24'h831122, rd: 1'b0, wa: {7'h03, 7'h03}, wd: 16'h1122, miso: 24'h0};
        vecs[4] = '{mosi: 24'h7F0000, rd: 1'b1, wa: 14'h0, wd: 16'h0, miso: 24'h00BFBF};
`endif

        #25;
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #3;

        for (int v = 0; v < 5; v++) begin
            we0 = we_cnt;
            re0 = re_cnt;
            if (!vecs[v].rd) begin
                push_wr(vecs[v].wa[13:7], vecs[v].wd[15:8]);
                push_wr(vecs[v].wa[6:0],  vecs[v].wd[7:0]);
            end
            ss_low();
            for (int b = 0; b < 3; b++) begin
                spi_xfer(vecs[v].mosi[23 - 8*b -: 8], 8, got);
                rx[b] = got;
                if (b == 0) chk($sformatf("v%0d_busy", v), int'(bus.busy), 1);
            end
            ss_high();
            chk($sformatf("v%0d_idle_busy", v), int'(bus.busy), 0);
            chk($sformatf("v%0d_idle_miso", v), int'(bus.my_spi_miso), 0);
            if (vecs[v].rd) begin
                for (int b = 0; b < 3; b++)
                    chk($sformatf("v%0d_miso%0d", v, b), int'(rx[b]),
                        int'(vecs[v].miso[23 - 8*b -: 8]));
                chk($sformatf("v%0d_re_count", v), re_cnt - re0, 3);
                chk($sformatf("v%0d_we_count", v), we_cnt - we0, 0);
            end else begin
                chk($sformatf("v%0d_we_count", v), we_cnt - we0, 2);
                chk($sformatf("v%0d_re_count", v), re_cnt - re0, 0);
                chk($sformatf("v%0d_queue_left", v), exp_q.size(), 0);
            end
        end

        // ss rises after 5 bits of a data byte: no write, then a clean frame
        we0 = we_cnt;
        ss_low();
        spi_xfer(8'h85, 8, got);
        spi_xfer(8'hAA, 5, got);
        ss_high();
        chk("abort_no_we", we_cnt - we0, 0);
        push_wr(7'h01, 8'h77);
        ss_low();
        spi_xfer(8'h81, 8, got);
        spi_xfer(8'h77, 8, got);
        ss_high();
        chk("after_abort_we", we_cnt - we0, 1);
        chk("after_abort_queue", exp_q.size(), 0);

        // Reset pulsed mid data byte: outputs clear at once, no strobes until
        // ss goes high and a fresh frame starts
        we0 = we_cnt;
        re0 = re_cnt;
        ss_low();
        spi_xfer(8'h85, 8, got);
        spi_xfer(8'hC3, 4, got);
        #30;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        #40;
        rst_n = 1'b1;
        spi_xfer(8'h3C, 4, got);
        spi_xfer(8'h99, 8, got);
        chk("rst_mid_busy", int'(bus.busy), 0);
        ss_high();
        chk("rst_mid_no_we", we_cnt - we0, 0);
        chk("rst_mid_no_re", re_cnt - re0, 0);
        push_wr(7'h01, 8'h77);
        ss_low();
        spi_xfer(8'h81, 8, got);
        spi_xfer(8'h77, 8, got);
        ss_high();
        chk("after_rst_we", we_cnt - we0, 1);
        chk("after_rst_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 clk  in  1  system clock (50 MHz on board); all state SHALL be clocked on its rising edge.
REQ-002 rst_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-003 my_spi_ss  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-004 my_spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 my_spi_mosi  in  1  SPI data in, MSB first.
REQ-006 my_spi_miso  out  1  SPI data out, MSB first; SHALL be 0 while my_spi_ss is high.
REQ-007 reg_addr  out  7  current register address presented to the downstream register bank/mux.
REQ-008 reg_wdata  out  8  write data; SHALL be valid in the cycle reg_we is high.
REQ-009 reg_we  out  1  single-cycle write strobe.
REQ-010 reg_re  out  1  single-cycle read strobe; reg_rdata SHALL be sampled exactly 1 cycle later.
REQ-011 reg_rdata  in  8  read data returned by the register bank.
REQ-012 busy  out  1  high from synchronized my_spi_ss fall to synchronized rise.

Function
REQ-013 my_spi_ss, my_spi_sck and my_spi_mosi SHALL each pass a 2-flop synchronizer; sck rise/fall SHALL be detected from the synchronized samples.
REQ-014 Supported sck frequency SHALL be at most clk/16.
REQ-015 MOSI SHALL be shifted in on the detected sck rise; a 3-bit counter SHALL mark byte completion on the 8th rise.
REQ-016 FSM states: IDLE, CMD, DATA.
REQ-017 IDLE->CMD on synchronized ss fall; the bit counter SHALL be cleared on entry.
REQ-018 First byte = command: bit 7 = 1 write, 0 read; bits 6:0 = start address loaded into reg_addr; CMD->DATA on byte completion.
REQ-019 Read command: reg_re SHALL pulse 1 cycle after command completion; reg_rdata SHALL be loaded into the TX shift register before the next sck fall.
REQ-020 DATA, write: each completed byte SHALL drive reg_wdata and pulse reg_we 1 cycle after completion.
REQ-021 DATA, read: each completed byte (MOSI ignored) SHALL advance the address per REQ-030 and pulse reg_re for the next byte.
REQ-022 MISO SHALL change only on the detected sck fall; MISO SHALL shift out 0x00 during the command byte.
REQ-023 Address arithmetic SHALL be 7-bit modulo: 0x7F+1 = 0x00.
REQ-024 Any state -> IDLE on synchronized ss rise; a partial byte SHALL be discarded with no strobe.
REQ-025 ss rise coinciding with byte completion: ss SHALL take priority; no strobe issued.
REQ-026 reg_we and reg_re SHALL never be high in the same cycle.

Reset
REQ-027 On rst_n low: FSM = IDLE; reg_addr = 0x00; reg_wdata = 0x00; reg_we = 0; reg_re = 0; busy = 0; my_spi_miso = 0; shift registers and counters = 0; synchronizers = ss 1, sck 0, mosi 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh ss fall (no mid-frame resynchronization).

Configuration
REQ-029 Macro SPI_AUTOINC_EN selects address auto-increment.
REQ-030 With SPI_AUTOINC_EN defined: reg_addr SHALL increment by 1 after each data-byte strobe. Without it: reg_addr SHALL stay at the command address for the whole frame (FIFO-style port access).

Structure
REQ-031 Package spi_reg_pkg SHALL hold: FSM state enum; ADDR_W=7; DATA_W=8; CMD_WR_BIT=7.
REQ-032 Sub-module spi_sync (2-flop synchronizer plus rise/fall detect) SHALL be instantiated once per SPI input.

Verification
REQ-033 Write 0x85,0xAA,0x55 with SPI_AUTOINC_EN -> reg_we pulses with (addr,data) = (0x05,0xAA) then (0x06,0x55).
REQ-034 Read 0x10, then 2 dummy bytes, bank returns addr+0x40 -> MISO bytes 0x00,0x50,0x51.
REQ-035 Write 0xFF,0x01,0x02 with SPI_AUTOINC_EN -> writes to 0x7F then 0x00 (wrap).
REQ-036 Write 0x83,0x11,0x22 without SPI_AUTOINC_EN -> both writes to 0x03.
REQ-037 ss rises after 5 bits of a data byte -> no reg_we; next frame 0x81,0x77 writes 0x77 to 0x01.
REQ-038 rst_n pulsed low mid data byte -> all outputs at REQ-027 values within 1 cycle; no strobe until a new frame.
